// File: rtl/sram_bus_pkg.sv
// Shared types and constants for the SLC-3 to async-SRAM bus controller.
package sram_bus_pkg;

    localparam int   SRAM_ADDR_W = 20;
    localparam int   CPU_ADDR_W  = 16;
    localparam int   DATA_W      = 16;
    localparam logic STROBE_OFF  = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        WR_SETUP,
        ACCESS,
        DONE
    } state_e;

    // Expands a 2-bit byte-enable into a per-bit mask (bit1 = upper byte).
    function automatic logic [DATA_W-1:0] lane_mask(input logic [1:0] be);
        return {{(DATA_W/2){be[1]}}, {(DATA_W/2){be[0]}}};
    endfunction

endpackage

// File: rtl/sram_bus_ctrl.sv
// Sequences CE/OE/WE/UB/LB and the shared Data bus of a 16-bit async SRAM for single CPU requests.
// Optional byte-lane support is enabled with `define SRAM_BYTE_LANE_EN.
module sram_bus_ctrl
    import sram_bus_pkg::*;
#(
    parameter int WAIT_CYCLES = 1
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   mem_req,
    input  logic                   mem_we,
    input  logic [CPU_ADDR_W-1:0]  mem_addr,
    input  logic [DATA_W-1:0]      mem_wdata,
`ifdef SRAM_BYTE_LANE_EN
    input  logic [1:0]             mem_be,
`endif
    output logic [DATA_W-1:0]      mem_rdata,
    output logic                   mem_ready,
    output logic                   busy,
    output logic [SRAM_ADDR_W-1:0] ADDR,
    inout  wire  [DATA_W-1:0]      Data,
    output logic                   CE,
    output logic                   OE,
    output logic                   WE,
    output logic                   UB,
    output logic                   LB
);

    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);

    state_e                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    we_q;
    logic [CPU_ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]       wdata_q;
    logic [DATA_W-1:0]       rdata_q;
    logic [DATA_W-1:0]       rdata_d;
    logic                    ready_q;
    logic                    busy_q;
    logic                    ce_q;
    logic                    oe_q;
    logic                    wen_q;
    logic                    drive_q;

`ifdef SRAM_BYTE_LANE_EN
    logic [1:0]              be_q;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            be_q <= 2'b00;
        end else if (state_q == IDLE && mem_req) begin
            be_q <= mem_be;
        end
    end

    // Disabled lanes read as zero; their strobes stay off even while CE is low.
    assign rdata_d = Data & lane_mask(be_q);
    assign UB      = ce_q | ~be_q[1];
    assign LB      = ce_q | ~be_q[0];
`else
    assign rdata_d = Data;
    assign UB      = ce_q;
    assign LB      = ce_q;
`endif

    // All strobes are registered so the SRAM pins never glitch on state decode.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            ce_q    <= STROBE_OFF;
            oe_q    <= STROBE_OFF;
            wen_q   <= STROBE_OFF;
            drive_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout keep every register reading pre-edge values.
            ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mem_req) begin
                        we_q    <= mem_we;
                        addr_q  <= mem_addr;
                        wdata_q <= mem_wdata;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        ce_q    <= 1'b0;
                        if (mem_we) begin
                            state_q <= WR_SETUP;
                            drive_q <= 1'b1;
                        end else begin
                            state_q <= ACCESS;
                            oe_q    <= 1'b0;
                        end
                    end
                end
                WR_SETUP: begin
                    state_q <= ACCESS;
                    wen_q   <= 1'b0;
                end
                ACCESS: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q <= DONE;
                        oe_q    <= STROBE_OFF;
                        wen_q   <= STROBE_OFF;
                        ready_q <= 1'b1;
                        if (!we_q) begin
                            rdata_q <= rdata_d;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    // Write data stays on the bus through DONE as hold time after WE rises.
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    ce_q    <= STROBE_OFF;
                    drive_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    ce_q    <= STROBE_OFF;
                    oe_q    <= STROBE_OFF;
                    wen_q   <= STROBE_OFF;
                    drive_q <= 1'b0;
                end
            endcase
        end
    end

    assign Data      = drive_q ? wdata_q : {DATA_W{1'bz}};
    assign ADDR      = {{(SRAM_ADDR_W - CPU_ADDR_W){1'b0}}, addr_q};
    assign CE        = ce_q;
    assign OE        = oe_q;
    assign WE        = wen_q;
    assign mem_rdata = rdata_q;
    assign mem_ready = ready_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sram_bus_ctrl.sv
// Scoreboard bench for sram_bus_ctrl: behavioural async SRAM, transaction-level reference model.
module tb_sram_bus_ctrl;

    localparam int W = 1;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    int unsigned cyc = 0;

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    // Main DUT (WAIT_CYCLES = W)
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [15:0] mem_addr = '0;
    logic [15:0] mem_wdata = '0;
`ifdef SRAM_BYTE_LANE_EN
    logic [1:0]  mem_be = 2'b11;
`endif
    logic [15:0] mem_rdata;
    logic        mem_ready, busy;
    logic [19:0] ADDR;
    wire  [15:0] data_bus;
    logic        CE, OE, WE, UB, LB;

    sram_bus_ctrl #(.WAIT_CYCLES(W)) u_dut (
        .Clk(Clk), .Reset(Reset),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
`ifdef SRAM_BYTE_LANE_EN
        .mem_be(mem_be),
`endif
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy),
        .ADDR(ADDR), .Data(data_bus), .CE(CE), .OE(OE), .WE(WE), .UB(UB), .LB(LB)
    );

    // Second DUT with no wait states
    logic        req0 = 1'b0;
    logic [15:0] addr0 = '0;
    logic [15:0] rdata0;
    logic        ready0, busy0;
    logic [19:0] ADDR0;
    wire  [15:0] data0;
    logic        CE0, OE0, WE0, UB0, LB0;

    sram_bus_ctrl #(.WAIT_CYCLES(0)) u_dut0 (
        .Clk(Clk), .Reset(Reset),
        .mem_req(req0), .mem_we(1'b0), .mem_addr(addr0), .mem_wdata(16'h0000),
`ifdef SRAM_BYTE_LANE_EN
        .mem_be(2'b11),
`endif
        .mem_rdata(rdata0), .mem_ready(ready0), .busy(busy0),
        .ADDR(ADDR0), .Data(data0), .CE(CE0), .OE(OE0), .WE(WE0), .UB(UB0), .LB(LB0)
    );

    assign data0 = (!CE0 && !OE0 && WE0) ? (16'hC3A5 ^ ADDR0[15:0]) : 16'bz;

    // Behavioural async SRAM for the main DUT
    logic [15:0] sram_mem [65536];
    logic [15:0] ref_mem  [65536];

    assign data_bus = (!CE && !OE && WE) ? sram_mem[ADDR[15:0]] : 16'bz;

    always @(negedge Clk) begin
        if (Reset && !CE && !WE) begin
            if (!UB) sram_mem[ADDR[15:0]][15:8] = data_bus[15:8];
            if (!LB) sram_mem[ADDR[15:0]][7:0]  = data_bus[7:0];
        end
    end

    // Scoreboard
    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
        logic [15:0] rdata;
        int unsigned issue;
    } txn_t;

    txn_t        exp_q[$];
    logic [15:0] last_rd = '0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          oe_cnt = 0;
    int          we_cnt = 0;
    int          rdy_cnt = 0;
    bit          mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [15:0] byte_mask(input logic [1:0] be);
        logic [15:0] m;
        m = 16'h0000;
        if (be[1]) m = m | 16'hFF00;
        if (be[0]) m = m | 16'h00FF;
        return m;
    endfunction

    // Reference model: one call per accepted request, applied in issue order.
    task automatic model_push(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                              input logic [1:0] be);
        txn_t t;
        t.we = we; t.addr = addr; t.wdata = wdata; t.be = be; t.issue = cyc;
        if (we) begin
            ref_mem[addr] = (ref_mem[addr] & ~byte_mask(be)) | (wdata & byte_mask(be));
            t.rdata = last_rd;
        end else begin
            t.rdata = ref_mem[addr] & byte_mask(be);
            last_rd = t.rdata;
        end
        exp_q.push_back(t);
    endtask

    // Monitor: samples on the falling edge, away from the DUT's active edge.
    always @(negedge Clk) begin
        if (!Reset || !mon_en) begin
            oe_cnt = 0;
            we_cnt = 0;
        end else begin
            if (!OE) oe_cnt++;
            if (!WE) we_cnt++;
            if (!busy) begin
                check("idle_strobes", 32'({CE, OE, WE, UB, LB}), 32'h1F);
                check("idle_no_ready", 32'(mem_ready), 32'h0);
            end else if (exp_q.size() == 0) begin
                check("busy_without_request", 32'(busy), 32'h0);
            end else begin
                check("ce_low_while_busy", 32'(CE), 32'h0);
                check("addr", 32'(ADDR), 32'({4'h0, exp_q[0].addr}));
                check("oe_we_exclusive", 32'(!OE && !WE), 32'h0);
`ifdef SRAM_BYTE_LANE_EN
                check("byte_lanes", 32'({UB, LB}), 32'(~exp_q[0].be));
`else
                check("byte_lanes", 32'({UB, LB}), 32'({CE, CE}));
`endif
                if (!WE) check("write_data", 32'(data_bus), 32'(exp_q[0].wdata));
                if (mem_ready) begin
                    rdy_cnt++;
                    check("latency", cyc - exp_q[0].issue, exp_q[0].we ? W + 3 : W + 2);
                    check("rdata", 32'(mem_rdata), 32'(exp_q[0].rdata));
                    check("oe_low_cycles", oe_cnt, exp_q[0].we ? 0 : W + 1);
                    check("we_low_cycles", we_cnt, exp_q[0].we ? W + 1 : 0);
                    void'(exp_q.pop_front());
                    oe_cnt = 0;
                    we_cnt = 0;
                end
            end
        end
    end

    task automatic scramble();
        mem_we    = 1'($urandom);
        mem_addr  = 16'($urandom);
        mem_wdata = 16'($urandom);
`ifdef SRAM_BYTE_LANE_EN
        mem_be    = 2'($urandom);
`endif
        mem_req   = 1'($urandom);
    endtask

    // Waits for a falling edge with busy low; inputs are garbage (incl. req) while busy.
    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge Clk);
            if (!busy) begin
                ok = 1'b1;
                return;
            end
            scramble();
        end
        check("wait_idle_timeout", 32'(busy), 32'h0);
    endtask

    task automatic do_txn(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                          input logic [1:0] be);
        bit ok;
        wait_idle(ok);
        if (!ok) return;
        mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_wdata = wdata;
`ifdef SRAM_BYTE_LANE_EN
        mem_be = be;
`endif
        model_push(we, addr, wdata, be);
        @(negedge Clk);
        scramble();
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            mem_req = 1'b0;
            @(negedge Clk);
            if (exp_q.size() == 0 && !busy) return;
        end
        check("drain_timeout", exp_q.size(), 0);
    endtask

    initial begin
        int rdy_start;
        int lat0;
        int oe0;
        bit ok;

        for (int i = 0; i < 65536; i++) begin
            sram_mem[i] = 16'(i) ^ 16'h5A5A;
            ref_mem[i]  = 16'(i) ^ 16'h5A5A;
        end

        #3 Reset = 1'b0;
        #1;
        check("rst_strobes", 32'({CE, OE, WE, UB, LB}), 32'h1F);
        check("rst_addr", 32'(ADDR), 32'h0);
        check("rst_rdata", 32'(mem_rdata), 32'h0);
        check("rst_ready_busy", 32'({mem_ready, busy}), 32'h0);
        check("rst0_strobes", 32'({CE0, OE0, WE0, busy0, ready0}), 32'h1C);
        repeat (2) @(negedge Clk);
        Reset = 1'b1;

        // Reset asserted in the middle of a write access
        @(negedge Clk);
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 16'h8000; mem_wdata = 16'hAAAA;
`ifdef SRAM_BYTE_LANE_EN
        mem_be = 2'b11;
`endif
        @(negedge Clk);
        mem_req = 1'b0;
        @(negedge Clk);
        check("pre_abort_we_low", 32'({CE, WE}), 32'h0);
        #2 Reset = 1'b0;
        #1;
        check("abort_strobes", 32'({CE, OE, WE}), 32'h7);
        check("abort_ready_busy", 32'({mem_ready, busy}), 32'h0);
        check("abort_addr", 32'(ADDR), 32'h0);
        for (int i = 0; i < 2; i++) begin
            @(negedge Clk);
            check("abort_no_ready", 32'(mem_ready), 32'h0);
        end
        Reset = 1'b1;
        @(negedge Clk);
        check("after_abort_idle", 32'({busy, CE, OE, WE}), 32'h7);
        check("after_abort_rdata", 32'(mem_rdata), 32'h0);
        last_rd = 16'h0000;
        mon_en = 1'b1;

        // Write then read back with W wait states
        do_txn(1'b1, 16'h0003, 16'hBEEF, 2'b11);
        do_txn(1'b0, 16'h0003, 16'h0000, 2'b11);
        drain();
        check("readback_beef", 32'(mem_rdata), 32'hBEEF);

        // Zero-wait DUT: read at the top of the CPU address space
        @(negedge Clk);
        req0 = 1'b1; addr0 = 16'hFFFF;
        lat0 = -1;
        oe0 = 0;
        for (int i = 1; i <= 10 && lat0 < 0; i++) begin
            @(negedge Clk);
            req0 = 1'b0;
            addr0 = 16'($urandom);
            if (!OE0) oe0++;
            if (!CE0) check("w0_addr", 32'(ADDR0), 32'h0FFFF);
            if (ready0) lat0 = i;
        end
        check("w0_latency", lat0, 2);
        check("w0_oe_cycles", oe0, 1);
        check("w0_rdata", 32'(rdata0), 32'h3C5A);

        // mem_req held high: back-to-back reads with a one-cycle idle gap
        wait_idle(ok);
        rdy_start = rdy_cnt;
        for (int i = 0; i < 2 * (W + 3) + 1; i++) begin
            mem_req = 1'b1; mem_we = 1'b0; mem_addr = 16'h0005;
`ifdef SRAM_BYTE_LANE_EN
            mem_be = 2'b11;
`endif
            if (i % (W + 3) == 0) model_push(1'b0, 16'h0005, 16'h0000, 2'b11);
            @(negedge Clk);
        end
        mem_req = 1'b0;
        drain();
        repeat (W + 4) @(negedge Clk);
        check("held_req_ready_count", rdy_cnt - rdy_start, 3);

`ifdef SRAM_BYTE_LANE_EN
        do_txn(1'b1, 16'h0010, 16'hFFFF, 2'b11);
        do_txn(1'b1, 16'h0010, 16'h1234, 2'b10);
        do_txn(1'b0, 16'h0010, 16'h0000, 2'b11);
        do_txn(1'b0, 16'h0010, 16'h0000, 2'b01);
        do_txn(1'b0, 16'h0010, 16'h0000, 2'b00);
        drain();
`endif

        // Randomized traffic with input scrambling during every access
        for (int n = 0; n < 60; n++) begin
            logic [1:0] be;
`ifdef SRAM_BYTE_LANE_EN
            be = 2'($urandom);
`else
            be = 2'b11;
`endif
            do_txn(1'($urandom), 16'($urandom_range(0, 63)), 16'($urandom), be);
        end
        drain();
        check("queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
